// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-queue entry layout used by the instruction fetch unit.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-3:0] word_index(input logic [XLEN-1:0] byte_addr);
        return byte_addr[XLEN-1:2];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; pushes into a full FIFO and pops from an empty one are ignored.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC owner, credit-limited memory reads, fetch FIFO to decode, redirect flush.
// Define MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of forcing alignment.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter int          MAX_OUTST   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [29:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);

    localparam int CW  = $clog2(MAX_OUTST) + 1;
    localparam int FCW = $clog2(QUEUE_DEPTH + 1);
    localparam int TCW = $clog2(MAX_OUTST + 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   outst_nxt;
    logic [CW-1:0]   drop;
    logic            run;
    logic            fault_hold;
    logic            accept;
    logic            discard;
    logic            fifo_empty;
    logic [FCW-1:0]  fifo_count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic [XLEN-1:0] tag_pc;
    logic            tag_empty;
    logic [TCW-1:0]  tag_count;
    logic            unused_tag;

    // run holds requests off for the first cycle after reset release
    assign mem_req_valid = run && !fault_hold
                        && (32'(outst) + 32'(fifo_count) < 32'(QUEUE_DEPTH))
                        && (32'(outst) < 32'(MAX_OUTST));
    assign mem_req_addr  = word_index(pc);
    assign accept        = mem_req_valid && mem_req_ready;
    assign outst_nxt     = outst + CW'(accept) - CW'(mem_resp_valid);
    assign discard       = redirect_valid || (drop != '0);
    assign push_entry    = '{instr: mem_resp_instr, pc: tag_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            outst <= '0;
            drop  <= '0;
            run   <= 1'b0;
        end else begin
            run   <= 1'b1;
            outst <= outst_nxt;
            if (redirect_valid) begin
                pc   <= redirect_target;
                // every read still in flight after this edge belongs to the old path
                drop <= outst_nxt;
            end else begin
                if (accept) pc <= pc + PC_STEP;
                if (mem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign redirect_target = redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fault_hold <= 1'b0;
        else if (redirect_valid) fault_hold <= (redirect_pc[1:0] != 2'b00);
    end
`else
    logic unused_align;
    assign unused_align    = ^redirect_pc[1:0];
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign fault_hold      = 1'b0;
`endif

    assign fetch_fault = fault_hold;

    fetch_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (mem_resp_valid && !discard),
        .push_data (push_entry),
        .pop       (id_valid && id_ready),
        .head      (head_entry),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Request PCs in issue order; never flushed so dropped responses still retire their tag.
    fetch_fifo #(.DEPTH(MAX_OUTST), .WIDTH(XLEN)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (accept),
        .push_data (pc),
        .pop       (mem_resp_valid),
        .head      (tag_pc),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    assign unused_tag = ^{tag_empty, tag_count};

    assign id_valid = !fifo_empty && !fault_hold;
    assign id_instr = id_valid ? head_entry.instr : INSTR_NOP;
    assign id_pc    = id_valid ? head_entry.pc : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-configurable memory model and id-stream scoreboard.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [29:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fetch_fault;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_instr (mem_resp_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [29:0] addr;
    } resp_t;

    resp_t       resp_q[$];
    logic [63:0] exp_q[$];     // {instr, pc} in expected decode order

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          consumed = 0;
    int          lat      = 1;
    int          stall_acc = 0;
    bit          rand_ready = 0;
    bit          stall      = 0;
    bit          redir_now  = 0;
    bit          redir_busy = 0;
    bit          prev_redir = 0;
    logic [31:0] redir_target = '0;

    function automatic logic [31:0] mem_fn(input logic [29:0] waddr);
        return {waddr, 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] start, input int n);
        logic [31:0] p;
        exp_q.delete();
        p = start;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({mem_fn(p[31:2]), p});
            p = p + 32'd4;
        end
    endtask

    // One clock: memory model, request/decode handshakes and redirects, all decided at the negedge.
    task automatic cycle();
        logic        resp_now;
        logic        acc;
        logic [63:0] e;
        @(negedge clk);
        cyc++;
        if (prev_redir) check("flush_id_valid", 64'(id_valid), 64'd0);
        prev_redir = 0;
        resp_now = (resp_q.size() > 0) && (resp_q[0].due <= cyc);
        if (resp_now) begin
            mem_resp_valid = 1'b1;
            mem_resp_instr = mem_fn(resp_q[0].addr);
            resp_q.delete(0);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_instr = '0;
        end
        mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = mem_req_valid && mem_req_ready;
        if (acc) begin
            resp_q.push_back('{due: cyc + lat, addr: mem_req_addr});
            if (stall) stall_acc++;
        end
        redirect_valid = 1'b0;
        if (redir_now || (redir_busy && acc && resp_now)) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_target;
            redir_now      = 0;
            redir_busy     = 0;
            prev_redir     = 1;
        end
        id_ready = (redirect_valid || stall) ? 1'b0 : 1'b1;
        if (id_valid && !id_ready && exp_q.size() > 0)
            check("stall_hold_pc", 64'(id_pc), 64'(exp_q[0][31:0]));
        if (id_valid && id_ready) begin
            consumed++;
            if (exp_q.size() == 0) begin
                check("unexpected_instr_pc", 64'(id_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("id_pc", 64'(id_pc), 64'(e[31:0]));
                check("id_instr", 64'(id_instr), 64'(e[63:32]));
            end
        end
        if (redirect_valid) begin
`ifdef MISALIGN_TRAP_EN
            if (redir_target[1:0] != 2'b00) exp_q.delete();
            else fill(redir_target, 64);
`else
            fill({redir_target[31:2], 2'b00}, 64);
`endif
        end
    endtask

    task automatic run_until(input string tag, input int n, input int budget);
        int target;
        int k;
        target = consumed + n;
        k = 0;
        while (consumed < target && k < budget) begin
            cycle();
            k++;
        end
        check(tag, 64'(consumed), 64'(target));
    endtask

    initial begin
        int k;
        rst_n          = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_instr = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_req_addr",  64'(mem_req_addr),  64'd0);
        check("rst_id_valid",      64'(id_valid),      64'd0);
        check("rst_id_instr",      64'(id_instr),      64'h13);
        check("rst_id_pc",         64'(id_pc),         64'd0);
        check("rst_fetch_fault",   64'(fetch_fault),   64'd0);
        fill(32'h0, 64);
        rst_n = 1'b1;

        // streaming from RESET_PC, 1-cycle memory
        run_until("stream_progress", 10, 200);

        // decode stall: credits bound issue, head held, nothing lost afterwards
        stall = 1;
        stall_acc = 0;
        repeat (5) cycle();
        check("stall_req_valid_low", 64'(mem_req_valid), 64'd0);
        check("stall_id_valid",      64'(id_valid),      64'd1);
        check("stall_accepts_le2",   64'(stall_acc <= 2), 64'd1);
        stall = 0;
        run_until("release_progress", 8, 200);

        // reads in flight with slow memory, redirect
        lat = 3;
        repeat (6) cycle();
        redir_target = 32'h0000_0100;
        redir_now = 1;
        cycle();
        run_until("redirect_0x100_progress", 8, 300);

        // redirect coinciding with a response and an accepted request
        lat = 1;
        redir_target = 32'h0000_0040;
        redir_busy = 1;
        k = 0;
        while (redir_busy && k < 200) begin
            cycle();
            k++;
        end
        check("busy_redirect_fired", 64'(redir_busy), 64'd0);
        run_until("busy_redirect_progress", 8, 300);

        // PC wraps past the top of the address space
        redir_target = 32'hFFFF_FFF8;
        redir_now = 1;
        cycle();
        run_until("wrap_progress", 6, 300);

        // random memory ready with 3-cycle latency
        rand_ready = 1;
        lat = 3;
        redir_target = 32'h0000_1000;
        redir_now = 1;
        cycle();
        run_until("random_ready_progress", 30, 2000);
        rand_ready = 0;

        // misaligned redirect target
        redir_target = 32'h0000_0102;
        redir_now = 1;
        cycle();
        cycle();
`ifdef MISALIGN_TRAP_EN
        repeat (6) cycle();
        check("trap_fetch_fault",   64'(fetch_fault),   64'd1);
        check("trap_req_valid_low", 64'(mem_req_valid), 64'd0);
        check("trap_id_valid_low",  64'(id_valid),      64'd0);
        redir_target = 32'h0000_0200;
        redir_now = 1;
        cycle();
        cycle();
        check("trap_cleared", 64'(fetch_fault), 64'd0);
        run_until("after_trap_progress", 8, 300);
`else
        check("no_trap_fetch_fault", 64'(fetch_fault), 64'd0);
        run_until("aligned_forced_progress", 8, 300);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
